// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH+1 clock throughput.
// Define SEQ_MULT_SIGNED_EN for two's complement operands and product.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] P,
   output logic               busy,
   output logic               done
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    p_q, p_d;
   logic [WIDTH-1:0] a_mag, b_mag;
`ifdef SEQ_MULT_SIGNED_EN
   logic             sign_q, sign_d;
`endif

   // Operand magnitudes fed to the unsigned core
   always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
      a_mag = A[WIDTH-1] ? (~A) + WIDTH'(1) : A;
      b_mag = B[WIDTH-1] ? (~B) + WIDTH'(1) : B;
`else
      a_mag = A;
      b_mag = B;
`endif
   end

   // Next-state and datapath update for the shift-add sequence
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
`ifdef SEQ_MULT_SIGNED_EN
      sign_d   = sign_q;
`endif
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               acc_d    = '0;
               cnt_d    = '0;
`ifdef SEQ_MULT_SIGNED_EN
               sign_d   = A[WIDTH-1] ^ B[WIDTH-1];
`endif
               state_d  = RUN;
            end else begin
               state_d  = IDLE;
            end
         end
         RUN: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
`ifdef SEQ_MULT_SIGNED_EN
               p_d = sign_q ? (~acc_d) + PW'(1) : acc_d;
`else
               p_d = acc_d;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         sign_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
`ifdef SEQ_MULT_SIGNED_EN
         sign_q   <= sign_d;
`endif
      end
   end

   assign P    = p_q;
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

endmodule
